utopia_rx_mphy: RTL and testbench

Parametrised multi-PHY Utopia receive controller. It polls up to NumPhy PHYs over a shared address/clav bus and selects one round-robin. It reads whole ATM cells from the selected PHY at 8- or 16-bit width and buffers complete cells in an internal FIFO with commit/rollback. Cells are presented to the switch core over a valid/ready word stream tagged with the source PHY. It sits between the PHY-side receive bus and the core receive path, replacing the single-PHY fixed-width receive port.

---
 rtl/utopia_rx_mphy_pkg.sv | 31 +++
 rtl/utopia_cell_fifo.sv | 102 ++++++++++
 rtl/utopia_rx_mphy.sv | 183 ++++++++++++++++++
 tb/tb_utopia_rx_mphy.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/utopia_rx_mphy_pkg.sv
// Shared definitions for the multi-PHY Utopia receive controller.
// Combinational helpers only; no state, no latency, no flow control.
// Cell geometry, HEC coset and FSM encoding used by top and FIFO.
package utopia_rx_mphy_pkg;

    localparam int         CELL_OCTETS = 53;
    localparam logic [7:0] HEC_COSET   = 8'h55;

    typedef enum logic [1:0] {
        ST_POLL   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_XFER   = 2'd2,
        ST_COMMIT = 2'd3
    } rx_state_e;

    // A 16-bit cell carries one extra UDF octet, so 54 octets = 27 words.
    function automatic int words_per_cell(input int width);
        return (width == 8) ? CELL_OCTETS : (CELL_OCTETS + 1) / 2;
    endfunction

    // One octet of CRC-8 (x^8+x^2+x+1), MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] octet);
        logic [7:0] c;
        c = crc ^ octet;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/utopia_cell_fifo.sv
// Word FIFO with speculative write side: words land uncommitted until commit, rollback discards them.
// Latency: committed words visible on rd_* the cycle after commit; read data is the head entry, no extra stage.
// Backpressure: head holds while rd_en_i is low; writer must check free_o before starting a cell.
module utopia_cell_fifo
    import utopia_rx_mphy_pkg::*;
#(
    parameter  int DataW = 8,
    parameter  int PhyW  = 2,
    parameter  int Depth = 106,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [DataW-1:0] wr_dat_i,
    input  logic             wr_soc_i,
    input  logic             wr_eoc_i,
    input  logic [PhyW-1:0]  wr_phy_i,
    input  logic             commit_i,
    input  logic             rollback_i,
    input  logic             rd_en_i,
    output logic [DataW-1:0] rd_dat_o,
    output logic             rd_soc_o,
    output logic             rd_eoc_o,
    output logic [PhyW-1:0]  rd_phy_o,
    output logic             nonempty_o,
    output logic [CntW-1:0]  free_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int EntW = DataW + PhyW + 2;

    logic [EntW-1:0] mem_q [Depth];
    logic [PtrW-1:0] wp_c_q, wp_c_d, wp_s_q, wp_s_d, rp_q, rp_d;
    logic [CntW-1:0] cnt_c_q, cnt_c_d, cnt_s_q, cnt_s_d;
    logic            nonempty_q;
    logic            wr_fire, rd_fire;
    logic [EntW-1:0] head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign wr_fire = wr_en_i && !commit_i && !rollback_i;
    assign rd_fire = rd_en_i && nonempty_q;

    always_comb begin
        wp_c_d  = wp_c_q;
        wp_s_d  = wp_s_q;
        rp_d    = rp_q;
        cnt_s_d = cnt_s_q;
        cnt_c_d = cnt_c_q - CntW'(rd_fire);
        if (rd_fire) begin
            rp_d = ptr_inc(rp_q);
        end
        if (rollback_i) begin
            wp_s_d  = wp_c_q;
            cnt_s_d = '0;
        end else if (commit_i) begin
            wp_c_d  = wp_s_q;
            cnt_c_d = cnt_c_d + cnt_s_q;
            cnt_s_d = '0;
        end else if (wr_fire) begin
            wp_s_d  = ptr_inc(wp_s_q);
            cnt_s_d = cnt_s_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wp_c_q     <= '0;
            wp_s_q     <= '0;
            rp_q       <= '0;
            cnt_c_q    <= '0;
            cnt_s_q    <= '0;
            nonempty_q <= 1'b0;
        end else begin
            wp_c_q     <= wp_c_d;
            wp_s_q     <= wp_s_d;
            rp_q       <= rp_d;
            cnt_c_q    <= cnt_c_d;
            cnt_s_q    <= cnt_s_d;
            nonempty_q <= (cnt_c_d != '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem_q[wp_s_q] <= {wr_phy_i, wr_eoc_i, wr_soc_i, wr_dat_i};
        end
    end

    // Slots between rp and wp_c are never rewritten, so the head is stable under backpressure.
    assign head       = mem_q[rp_q];
    assign rd_dat_o   = head[DataW-1:0];
    assign rd_soc_o   = nonempty_q && head[DataW];
    assign rd_eoc_o   = nonempty_q && head[DataW+1];
    assign rd_phy_o   = head[EntW-1:DataW+2];
    assign nonempty_o = nonempty_q;
    assign free_o     = CntW'(Depth) - cnt_c_q - cnt_s_q;

endmodule

// File: rtl/utopia_rx_mphy.sv
// Multi-PHY Utopia RX: round-robin poll, whole-cell reads into a commit/rollback FIFO; UTOPIA_HEC_CHECK_EN adds HEC drop.
// Latency: a cell is visible on cell_valid one cycle after its COMMIT; poll costs two cycles per PHY.
// Backpressure: cell_ready stalls the head word; a PHY is only selected when a whole cell of space is free.
module utopia_rx_mphy
    import utopia_rx_mphy_pkg::*;
#(
    parameter  int IfWidth   = 8,
    parameter  int NumPhy    = 4,
    parameter  int FifoCells = 2,
    localparam int AddrW     = (NumPhy > 1) ? $clog2(NumPhy) : 1
) (
    input  logic               clk_in,
    input  logic               reset_n,
    output logic [AddrW-1:0]   phy_addr,
    input  logic               clav,
    output logic               en,
    input  logic [IfWidth-1:0] data,
    input  logic               soc,
    output logic [IfWidth-1:0] cell_data,
    output logic               cell_soc,
    output logic               cell_eoc,
    output logic [AddrW-1:0]   cell_phy,
    output logic               cell_valid,
    input  logic               cell_ready,
    output logic               err_soc,
    output logic [15:0]        drop_cnt
);

    localparam int WordsPerCell = words_per_cell(IfWidth);
    localparam int Depth        = FifoCells * WordsPerCell;
    localparam int CntW         = $clog2(Depth + 1);

    rx_state_e        state_q, state_d;
    logic [AddrW-1:0] p_q, p_d, p_next;
    logic [5:0]       wcnt_q, wcnt_d;
    logic             err_q, err_d;
    logic [15:0]      drop_q;
    logic             drop_inc, fifo_wr, fifo_commit, fifo_rollback, last_word;
    logic [CntW-1:0]  free_words;

    assign p_next    = (p_q == AddrW'(NumPhy - 1)) ? '0 : p_q + 1'b1;
    assign last_word = (wcnt_q == 6'(WordsPerCell - 1));

`ifdef UTOPIA_HEC_CHECK_EN
    logic [7:0]  crc_q, crc_base, crc_hi, crc_word, hec_octet;
    logic        hec_bad_q, crc_en, hec_word;
    logic [15:0] data_x;

    assign data_x   = 16'(data);
    assign crc_base = (wcnt_q == 6'd0) ? 8'h00 : crc_q;

    always_comb begin
        crc_hi = crc8_step(crc_base, data_x[15:8]);
        if (IfWidth == 8) begin
            crc_word  = crc8_step(crc_base, data_x[7:0]);
            crc_en    = (wcnt_q < 6'd4);
            hec_word  = (wcnt_q == 6'd4);
            hec_octet = data_x[7:0];
        end else begin
            crc_word  = crc8_step(crc_hi, data_x[7:0]);
            crc_en    = (wcnt_q < 6'd2);
            hec_word  = (wcnt_q == 6'd2);
            hec_octet = data_x[15:8];
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            crc_q     <= 8'h00;
            hec_bad_q <= 1'b0;
        end else if (fifo_wr) begin
            if (crc_en) begin
                crc_q <= crc_word;
            end
            if (hec_word) begin
                hec_bad_q <= (hec_octet != (crc_q ^ HEC_COSET));
            end
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        wcnt_d        = wcnt_q;
        err_d         = 1'b0;
        drop_inc      = 1'b0;
        fifo_wr       = 1'b0;
        fifo_commit   = 1'b0;
        fifo_rollback = 1'b0;
        case (state_q)
            ST_POLL: state_d = ST_CHECK;
            ST_CHECK: begin
                if (clav && (free_words >= CntW'(WordsPerCell))) begin
                    state_d = ST_XFER;
                    wcnt_d  = '0;
                end else begin
                    state_d = ST_POLL;
                    p_d     = p_next;
                end
            end
            ST_XFER: begin
                // Framing: soc must be set on word 0 and only there.
                if ((wcnt_q == 6'd0) != soc) begin
                    err_d         = 1'b1;
                    drop_inc      = 1'b1;
                    fifo_rollback = 1'b1;
                    p_d           = p_next;
                    state_d       = ST_POLL;
                end else begin
                    fifo_wr = 1'b1;
                    if (last_word) begin
                        state_d = ST_COMMIT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                p_d     = p_next;
                state_d = ST_POLL;
`ifdef UTOPIA_HEC_CHECK_EN
                if (hec_bad_q) begin
                    fifo_rollback = 1'b1;
                    drop_inc      = 1'b1;
                end else begin
                    fifo_commit = 1'b1;
                end
`else
                fifo_commit = 1'b1;
`endif
            end
            default: state_d = ST_POLL;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_POLL;
            p_q     <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            if (drop_inc && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    utopia_cell_fifo #(
        .DataW (IfWidth),
        .PhyW  (AddrW),
        .Depth (Depth)
    ) u_fifo (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .wr_en_i    (fifo_wr),
        .wr_dat_i   (data),
        .wr_soc_i   (soc),
        .wr_eoc_i   (last_word),
        .wr_phy_i   (p_q),
        .commit_i   (fifo_commit),
        .rollback_i (fifo_rollback),
        .rd_en_i    (cell_valid && cell_ready),
        .rd_dat_o   (cell_data),
        .rd_soc_o   (cell_soc),
        .rd_eoc_o   (cell_eoc),
        .rd_phy_o   (cell_phy),
        .nonempty_o (cell_valid),
        .free_o     (free_words)
    );

    assign phy_addr = p_q;
    assign en       = (state_q == ST_XFER);
    assign err_soc  = err_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_utopia_rx_mphy.sv
// Directed bench: 8-bit/4-PHY/2-cell instance plus a 16-bit/2-PHY/1-cell instance driven by simple PHY models.
module tb_utopia_rx_mphy;

    typedef struct packed {
        logic [15:0] d;
        logic        soc;
        logic        eoc;
        logic [4:0]  phy;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [1:0]  phy_addr_a, cell_phy_a;
    logic        clav_a, en_a, soc_a, cell_soc_a, cell_eoc_a, cell_valid_a, cell_ready_a, err_soc_a;
    logic [7:0]  data_a, cell_data_a;
    logic [15:0] drop_cnt_a;

    logic [0:0]  phy_addr_b, cell_phy_b;
    logic        clav_b, en_b, soc_b, cell_soc_b, cell_eoc_b, cell_valid_b, cell_ready_b, err_soc_b;
    logic [15:0] data_b, cell_data_b;
    logic [15:0] drop_cnt_b;

    utopia_rx_mphy #(.IfWidth(8), .NumPhy(4), .FifoCells(2)) dut_a (
        .clk_in(clk), .reset_n(reset_n), .phy_addr(phy_addr_a), .clav(clav_a), .en(en_a),
        .data(data_a), .soc(soc_a), .cell_data(cell_data_a), .cell_soc(cell_soc_a),
        .cell_eoc(cell_eoc_a), .cell_phy(cell_phy_a), .cell_valid(cell_valid_a),
        .cell_ready(cell_ready_a), .err_soc(err_soc_a), .drop_cnt(drop_cnt_a)
    );

    utopia_rx_mphy #(.IfWidth(16), .NumPhy(2), .FifoCells(1)) dut_b (
        .clk_in(clk), .reset_n(reset_n), .phy_addr(phy_addr_b), .clav(clav_b), .en(en_b),
        .data(data_b), .soc(soc_b), .cell_data(cell_data_b), .cell_soc(cell_soc_b),
        .cell_eoc(cell_eoc_b), .cell_phy(cell_phy_b), .cell_valid(cell_valid_b),
        .cell_ready(cell_ready_b), .err_soc(err_soc_b), .drop_cnt(drop_cnt_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference HEC for header octets 00 01 02 03.
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    function automatic logic [7:0] oct(input int j);
        if (j == 4) return crc8(crc8(crc8(crc8(8'h00, 8'h00), 8'h01), 8'h02), 8'h03) ^ 8'h55;
        return 8'(j);
    endfunction

    // PHY models and output monitors, all on the falling edge.
    int    avail_a [4];
    int    avail_b [2];
    int    idx_a, idx_b, en_cyc_a, en_cyc_b, en_at2_a, err_cnt_a, err_addr_a;
    int    bad_soc_a = -1;
    bit    hec_corrupt_a = 1'b0;
    word_t qa[$];
    word_t qb[$];

    always @(negedge clk) begin
        word_t w;
        if (en_a) begin
            if (idx_a == 0) avail_a[phy_addr_a]--;
            data_a = oct(idx_a) ^ ((hec_corrupt_a && idx_a == 4) ? 8'hFF : 8'h00);
            soc_a  = (idx_a == 0) != (idx_a == bad_soc_a);
            if (phy_addr_a == 2'd2) en_at2_a++;
            idx_a++;
            en_cyc_a++;
        end else begin
            idx_a = 0; data_a = 8'h00; soc_a = 1'b0;
        end
        clav_a = (avail_a[phy_addr_a] > 0);
        if (en_b) begin
            if (idx_b == 0) avail_b[phy_addr_b]--;
            data_b = {oct(2 * idx_b), oct(2 * idx_b + 1)};
            soc_b  = (idx_b == 0);
            idx_b++;
            en_cyc_b++;
        end else begin
            idx_b = 0; data_b = 16'h0; soc_b = 1'b0;
        end
        clav_b = (avail_b[phy_addr_b] > 0);
        if (cell_valid_a && cell_ready_a) begin
            w.d = 16'(cell_data_a); w.soc = cell_soc_a; w.eoc = cell_eoc_a; w.phy = 5'(cell_phy_a);
            qa.push_back(w);
        end
        if (cell_valid_b && cell_ready_b) begin
            w.d = cell_data_b; w.soc = cell_soc_b; w.eoc = cell_eoc_b; w.phy = 5'(cell_phy_b);
            qb.push_back(w);
        end
        if (err_soc_a) begin
            err_cnt_a++;
            err_addr_a = phy_addr_a;
        end
    end

    // Number of words in a 53-word 8-bit cell starting at qa[base] that differ from the expected cell.
    function automatic int cell_errs_a(input int base, input int phy);
        int n = 0;
        if (base + 53 > qa.size()) return 53;
        for (int i = 0; i < 53; i++) begin
            if (qa[base+i].d != 16'(oct(i)) || qa[base+i].soc != (i == 0) ||
                qa[base+i].eoc != (i == 52) || qa[base+i].phy != 5'(phy)) n++;
        end
        return n;
    endfunction

    function automatic int cell_errs_b(input int phy);
        int n = 0;
        if (qb.size() < 27) return 27;
        for (int i = 0; i < 27; i++) begin
            if (qb[i].d != {oct(2 * i), oct(2 * i + 1)} || qb[i].soc != (i == 0) ||
                qb[i].eoc != (i == 26) || qb[i].phy != 5'(phy)) n++;
        end
        return n;
    endfunction

    task automatic clear_env();
        qa.delete(); qb.delete();
        en_cyc_a = 0; en_cyc_b = 0; en_at2_a = 0; err_cnt_a = 0; err_addr_a = -1;
        for (int i = 0; i < 4; i++) avail_a[i] = 0;
        for (int i = 0; i < 2; i++) avail_b[i] = 0;
        bad_soc_a = -1; hec_corrupt_a = 1'b0;
        cell_ready_a = 1'b0; cell_ready_b = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        clear_env();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int socs[$];
        reset_n = 1'b0;
        data_a = '0; soc_a = 1'b0; clav_a = 1'b0;
        data_b = '0; soc_b = 1'b0; clav_b = 1'b0;
        clear_env();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phy_addr", 32'(phy_addr_a), 32'd0);
        chk("rst_en", 32'(en_a), 32'd0);
        chk("rst_valid", 32'(cell_valid_a), 32'd0);
        chk("rst_err", 32'(err_soc_a), 32'd0);
        chk("rst_drop", 32'(drop_cnt_a), 32'd0);
        chk("rst_sof_eof", 32'({cell_soc_a, cell_eoc_a}), 32'd0);
        reset_n = 1'b1;

        // Single cell from PHY 2 (8-bit) and from PHY 1 (16-bit).
        avail_a[2] = 1; avail_b[1] = 1;
        cell_ready_a = 1'b1; cell_ready_b = 1'b1;
        for (int i = 0; i < 600 && (qa.size() < 53 || qb.size() < 27); i++) @(posedge clk);
        repeat (40) @(posedge clk);
        chk("t1_en_cycles", 32'(en_cyc_a), 32'd53);
        chk("t1_en_at_phy2", 32'(en_at2_a), 32'd53);
        chk("t1_out_words", 32'(qa.size()), 32'd53);
        chk("t1_cell_content", 32'(cell_errs_a(0, 2)), 32'd0);
        chk("t1_b_en_cycles", 32'(en_cyc_b), 32'd27);
        chk("t1_b_out_words", 32'(qb.size()), 32'd27);
        chk("t1_b_cell_content", 32'(cell_errs_b(1)), 32'd0);
        chk("t1_drop", 32'(drop_cnt_a), 32'd0);

        // Every PHY has two cells: round-robin order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < 4; i++) avail_a[i] = 2;
        cell_ready_a = 1'b1;
        for (int i = 0; i < 1500 && qa.size() < 8 * 53; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        socs.delete();
        foreach (qa[i]) if (qa[i].soc) socs.push_back(int'(qa[i].phy));
        chk("t2_cells", 32'(socs.size()), 32'd8);
        for (int k = 0; k < 5; k++) chk($sformatf("t2_order%0d", k), 32'(k < socs.size() ? socs[k] : -1), 32'(k % 4));
        chk("t2_last_cell", 32'(cell_errs_a(7 * 53, 3)), 32'd0);

        // Backpressure: only two cells fit, PHY 2 waits until space frees.
        do_reset();
        avail_a[0] = 1; avail_a[1] = 1; avail_a[2] = 1;
        repeat (300) @(posedge clk);
        #1;
        chk("t3_stall_en_cycles", 32'(en_cyc_a), 32'd106);
        chk("t3_stall_en", 32'(en_a), 32'd0);
        chk("t3_stall_valid", 32'(cell_valid_a), 32'd1);
        chk("t3_hold_head", 32'({cell_data_a, cell_soc_a, cell_phy_a}), 32'({8'h00, 1'b1, 2'd0}));
        cell_ready_a = 1'b1;
        for (int i = 0; i < 600 && qa.size() < 159; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        chk("t3_en_cycles", 32'(en_cyc_a), 32'd159);
        chk("t3_out_words", 32'(qa.size()), 32'd159);
        chk("t3_third_cell", 32'(cell_errs_a(106, 2)), 32'd0);

        // Mid-cell soc at word 10: dropped, err pulse, next PHY polled.
        do_reset();
        avail_a[0] = 1; bad_soc_a = 10; cell_ready_a = 1'b1;
        repeat (200) @(posedge clk);
        chk("t4_err_pulses", 32'(err_cnt_a), 32'd1);
        chk("t4_err_next_phy", 32'(err_addr_a), 32'd1);
        chk("t4_drop", 32'(drop_cnt_a), 32'd1);
        chk("t4_en_cycles", 32'(en_cyc_a), 32'd11);
        chk("t4_no_output", 32'(qa.size()), 32'd0);

`ifdef UTOPIA_HEC_CHECK_EN
        do_reset();
        avail_a[1] = 1; hec_corrupt_a = 1'b1; cell_ready_a = 1'b1;
        repeat (200) @(posedge clk);
        chk("hec_drop", 32'(drop_cnt_a), 32'd1);
        chk("hec_no_output", 32'(qa.size()), 32'd0);
        chk("hec_no_err", 32'(err_cnt_a), 32'd0);
`endif

        // Reset at word 20 of the second cell, with the first cell still buffered.
        do_reset();
        avail_a[0] = 2;
        for (int i = 0; i < 400 && en_cyc_a < 73; i++) @(posedge clk);
        #1;
        chk("t5_pre_en", 32'(en_a), 32'd1);
        chk("t5_pre_valid", 32'(cell_valid_a), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_en", 32'(en_a), 32'd0);
        chk("t5_rst_valid", 32'(cell_valid_a), 32'd0);
        clear_env();
        repeat (2) @(posedge clk);
        #1;
        avail_a[0] = 1; cell_ready_a = 1'b1;
        reset_n = 1'b1;
        for (int i = 0; i < 400 && qa.size() < 53; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        chk("t5_out_words", 32'(qa.size()), 32'd53);
        chk("t5_new_cell", 32'(cell_errs_a(0, 0)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
